// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store bridge between the memory pipeline stage and a
// single-port synchronous data memory with one-cycle read latency.
// Byte, halfword and word accesses. Sub-word stores use read-modify-write.
// Optional feature macro: MEM_ACCESS_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses skip memory and respond with RespError = 1
//   undefined : offending low address bits are forced to zero and the access proceeds
module mem_access_unit #(
   parameter int unsigned AddressSize = 16
) (
   input  logic                     Clock,
   input  logic                     nReset,
   input  logic                     ReqValid,
   output logic                     ReqReady,
   input  logic                     ReqWrite,
   input  logic [1:0]               ReqSize,
   input  logic                     ReqSigned,
   input  logic [AddressSize+1:0]   ReqAddr,
   input  logic [31:0]              ReqWData,
   output logic                     RespValid,
   input  logic                     RespReady,
   output logic [31:0]              RespData,
   output logic                     RespError,
   output logic                     MemWriteEn,
   output logic                     MemReadEn,
   output logic [AddressSize-1:0]   MemAddress,
   output logic [31:0]              MemWriteData,
   input  logic [31:0]              MemReadData
);

   typedef enum logic [2:0] {StIdle, StRead, StWait, StWrite, StResp} state_e;

   state_e                   r_state;
   state_e                   w_state_next;

   logic                     r_write;
   logic [1:0]               r_size;
   logic                     r_signed;
   logic [1:0]               r_offset;
   logic [AddressSize-1:0]   r_addr;
   logic [31:0]              r_wdata;
   logic [31:0]              r_resp_data;
   logic                     r_err;

   logic                     w_accept;
   logic                     w_trap;
   logic [1:0]               w_offset;
   logic [7:0]               w_lane_byte;
   logic [15:0]              w_lane_half;
   logic [31:0]              w_load_data;
   logic [31:0]              w_merged;

   assign w_accept   = ReqValid && (r_state == StIdle);
   assign MemAddress = r_addr;
   assign RespData   = r_resp_data;
   assign RespError  = r_err;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   logic w_misaligned;
   assign w_misaligned = ((ReqSize == 2'b01) && ReqAddr[0]) ||
                         (ReqSize[1] && (ReqAddr[1:0] != 2'b00));
   assign w_trap = w_misaligned;
`else
   assign w_trap = 1'b0;
`endif

   // Lane offset with misaligned low bits forced to zero for halves and words
   always_comb begin
      w_offset = 2'b00;
      unique case (ReqSize)
         2'b00:   w_offset = ReqAddr[1:0];
         2'b01:   w_offset = {ReqAddr[1], 1'b0};
         default: w_offset = 2'b00;
      endcase
   end

   // Load result: pick the addressed lane from the memory word and extend it
   always_comb begin
      w_lane_byte = MemReadData[7:0];
      unique case (r_offset)
         2'd0: w_lane_byte = MemReadData[7:0];
         2'd1: w_lane_byte = MemReadData[15:8];
         2'd2: w_lane_byte = MemReadData[23:16];
         2'd3: w_lane_byte = MemReadData[31:24];
      endcase
      w_lane_half = r_offset[1] ? MemReadData[31:16] : MemReadData[15:0];
      if (r_size[1]) begin
         w_load_data = MemReadData;
      end else if (r_size[0]) begin
         w_load_data = {{16{r_signed & w_lane_half[15]}}, w_lane_half};
      end else begin
         w_load_data = {{24{r_signed & w_lane_byte[7]}}, w_lane_byte};
      end
   end

   // Sub-word store: replace the target lane(s) of the fetched word
   always_comb begin
      w_merged = MemReadData;
      if (!r_size[1]) begin
         if (r_size[0]) begin
            if (r_offset[1]) w_merged[31:16] = r_wdata[15:0];
            else             w_merged[15:0]  = r_wdata[15:0];
         end else begin
            unique case (r_offset)
               2'd0: w_merged[7:0]   = r_wdata[7:0];
               2'd1: w_merged[15:8]  = r_wdata[7:0];
               2'd2: w_merged[23:16] = r_wdata[7:0];
               2'd3: w_merged[31:24] = r_wdata[7:0];
            endcase
         end
      end
   end

   // FSM state register
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) r_state <= StIdle;
      else         r_state <= w_state_next;
   end

   // FSM next-state and memory/handshake outputs
   always_comb begin
      w_state_next = r_state;
      ReqReady     = 1'b0;
      RespValid    = 1'b0;
      MemReadEn    = 1'b0;
      MemWriteEn   = 1'b0;
      MemWriteData = '0;
      unique case (r_state)
         StIdle: begin
            ReqReady = 1'b1;
            if (w_accept) begin
               if (w_trap)                     w_state_next = StResp;
               else if (ReqWrite && ReqSize[1]) w_state_next = StWrite;
               else                            w_state_next = StRead;
            end
         end
         StRead: begin
            MemReadEn    = 1'b1;
            w_state_next = StWait;
         end
         StWait: begin
            w_state_next = r_write ? StWrite : StResp;
         end
         StWrite: begin
            MemWriteEn   = 1'b1;
            MemWriteData = r_wdata;
            w_state_next = StResp;
         end
         StResp: begin
            RespValid = 1'b1;
            if (RespReady) w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   // Request latch, merged store word and response registers
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_write     <= 1'b0;
         r_size      <= 2'b00;
         r_signed    <= 1'b0;
         r_offset    <= 2'b00;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_resp_data <= '0;
         r_err       <= 1'b0;
      end else if (w_accept) begin
         r_write     <= ReqWrite;
         r_size      <= ReqSize;
         r_signed    <= ReqSigned;
         r_offset    <= w_offset;
         r_addr      <= ReqAddr[AddressSize+1:2];
         r_wdata     <= ReqWData;
         r_resp_data <= '0;
         r_err       <= w_trap;
      end else if (r_state == StWait) begin
         if (r_write) r_wdata     <= w_merged;
         else         r_resp_data <= w_load_data;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed spec scenarios followed by
// random traffic checked against a byte-addressed reference memory.
module tb_mem_access_unit;

   localparam int unsigned AddressSize = 16;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   localparam bit Trap = 1'b1;
`else
   localparam bit Trap = 1'b0;
`endif

   logic                   Clock = 1'b0;
   logic                   nReset;
   logic                   ReqValid;
   logic                   ReqReady;
   logic                   ReqWrite;
   logic [1:0]             ReqSize;
   logic                   ReqSigned;
   logic [AddressSize+1:0] ReqAddr;
   logic [31:0]            ReqWData;
   logic                   RespValid;
   logic                   RespReady;
   logic [31:0]            RespData;
   logic                   RespError;
   logic                   MemWriteEn;
   logic                   MemReadEn;
   logic [AddressSize-1:0] MemAddress;
   logic [31:0]            MemWriteData;
   logic [31:0]            MemReadData;

   int n_asserts = 0;
   int n_fail    = 0;
   int both_cnt  = 0;

   // Results of the most recent request
   logic [31:0]      last_data;
   logic             last_err;
   int               last_lat;
   bit               last_en_seen;
   logic [15:0]      last_en_addr;

   // Reference model: byte-addressed memory
   logic [7:0] refb [int unsigned];

   // Memory model: word-addressed, registered read data, cleared by reset
   logic [31:0] mem [int unsigned];

   always #25 Clock = ~Clock;

   mem_access_unit #(.AddressSize(AddressSize)) dut (
      .Clock        (Clock),
      .nReset       (nReset),
      .ReqValid     (ReqValid),
      .ReqReady     (ReqReady),
      .ReqWrite     (ReqWrite),
      .ReqSize      (ReqSize),
      .ReqSigned    (ReqSigned),
      .ReqAddr      (ReqAddr),
      .ReqWData     (ReqWData),
      .RespValid    (RespValid),
      .RespReady    (RespReady),
      .RespData     (RespData),
      .RespError    (RespError),
      .MemWriteEn   (MemWriteEn),
      .MemReadEn    (MemReadEn),
      .MemAddress   (MemAddress),
      .MemWriteData (MemWriteData),
      .MemReadData  (MemReadData)
   );

   always @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         mem.delete();
         MemReadData <= '0;
      end else begin
         if (MemWriteEn) mem[32'(MemAddress)] = MemWriteData;
         if (MemReadEn)
            MemReadData <= mem.exists(32'(MemAddress)) ? mem[32'(MemAddress)] : 32'h0;
      end
   end

   always @(posedge Clock) if (MemReadEn && MemWriteEn) both_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
   endfunction

   function automatic bit misal(input logic [1:0] sz, input int unsigned a);
      return (nbytes(sz) > 1) && ((a % nbytes(sz)) != 0);
   endfunction

   function automatic int unsigned eaddr(input logic [1:0] sz, input int unsigned a);
      return a - (a % nbytes(sz));
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] sz, input bit sg,
                                              input int unsigned a);
      logic [31:0] x = 0;
      int unsigned n = nbytes(sz);
      int unsigned e = eaddr(sz, a);
      for (int i = 0; i < int'(n); i++) begin
         logic [7:0] b = refb.exists(e + i) ? refb[e + i] : 8'h00;
         x = x + (32'(b) << (8 * i));
      end
      if (sg && n < 4 && x[8 * n - 1]) x = x | (32'hFFFF_FFFF << (8 * n));
      return x;
   endfunction

   task automatic model_store(input logic [1:0] sz, input int unsigned a, input logic [31:0] wd);
      int unsigned e = eaddr(sz, a);
      for (int i = 0; i < int'(nbytes(sz)); i++) refb[e + i] = 8'(wd >> (8 * i));
   endtask

   // Issue one request; hold > 0 keeps RespReady low for that many RESP cycles
   task automatic req(input bit wr, input logic [1:0] sz, input bit sg, input int unsigned addr,
                      input logic [31:0] wd, input int hold);
      int g = 0;
      @(negedge Clock);
      while (!ReqReady && g < 50) begin
         @(negedge Clock);
         g++;
      end
      if (!ReqReady) check("ready_timeout", 32'(ReqReady), 32'd1);
      ReqValid  = 1'b1;
      ReqWrite  = wr;
      ReqSize   = sz;
      ReqSigned = sg;
      ReqAddr   = 18'(addr);
      ReqWData  = wd;
      RespReady = (hold == 0);
      @(posedge Clock);
      #1 ReqValid = 1'b0;
      last_lat = 0;
      last_en_seen = 1'b0;
      last_en_addr = '0;
      do begin
         @(negedge Clock);
         last_lat++;
         if (MemReadEn || MemWriteEn) begin
            last_en_seen = 1'b1;
            last_en_addr = MemAddress;
         end
      end while (!RespValid && last_lat < 20);
      if (!RespValid) check("resp_timeout", 32'(RespValid), 32'd1);
      last_data = RespData;
      last_err  = RespError;
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            check("hold_valid", 32'(RespValid), 32'd1);
            check("hold_data", RespData, last_data);
            check("hold_ready", 32'(ReqReady), 32'd0);
            @(negedge Clock);
         end
         RespReady = 1'b1;
         @(negedge Clock);
         check("idle_ready", 32'(ReqReady), 32'd1);
         check("idle_valid", 32'(RespValid), 32'd0);
      end
   endtask

   // Request plus reference-model prediction and checks
   task automatic op(input string tag, input bit wr, input logic [1:0] sz, input bit sg,
                     input int unsigned addr, input logic [31:0] wd, input int hold);
      bit          exp_err = Trap && misal(sz, addr);
      int          exp_lat;
      logic [31:0] exp_data;
      if (exp_err)              exp_lat = 1;
      else if (!wr)             exp_lat = 3;
      else if (nbytes(sz) == 4) exp_lat = 2;
      else                      exp_lat = 4;
      exp_data = (wr || exp_err) ? 32'h0 : model_load(sz, sg, addr);
      req(wr, sz, sg, addr, wd, hold);
      if (wr && !exp_err) model_store(sz, addr, wd);
      check({tag, "_lat"}, 32'(last_lat), 32'(exp_lat));
      check({tag, "_err"}, 32'(last_err), 32'(exp_err));
      check({tag, "_data"}, last_data, exp_data);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(ReqReady), 32'd1);
      check({tag, "_rvalid"}, 32'(RespValid), 32'd0);
      check({tag, "_rerr"}, 32'(RespError), 32'd0);
      check({tag, "_rdata"}, RespData, 32'd0);
      check({tag, "_we"}, 32'(MemWriteEn), 32'd0);
      check({tag, "_re"}, 32'(MemReadEn), 32'd0);
      check({tag, "_maddr"}, 32'(MemAddress), 32'd0);
      check({tag, "_mwdata"}, MemWriteData, 32'd0);
   endtask

   initial begin
      int g;
      nReset    = 1'b0;
      ReqValid  = 1'b0;
      ReqWrite  = 1'b0;
      ReqSize   = 2'b00;
      ReqSigned = 1'b0;
      ReqAddr   = '0;
      ReqWData  = '0;
      RespReady = 1'b1;
      #10;
      check_reset_outputs("reset");
      repeat (2) @(negedge Clock);
      nReset = 1'b1;

      // Word store / word load round trip
      op("t1_sw", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
      check("t1_sw_lat2", 32'(last_lat), 32'd2);
      check("t1_sw_addr", 32'(last_en_addr), 32'h4);
      op("t1_lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
      check("t1_lw_val", last_data, 32'hDEAD_BEEF);
      check("t1_lw_lat3", 32'(last_lat), 32'd3);
      check("t1_lw_addr", 32'(last_en_addr), 32'h4);

      // Byte store into an existing word, then loads of each flavour
      op("t2_sw", 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 0);
      op("t2_sb", 1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_0080, 0);
      check("t2_sb_lat4", 32'(last_lat), 32'd4);
      op("t2_lbs", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0);
      check("t2_lbs_val", last_data, 32'hFFFF_FF80);
      op("t2_lbu", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0);
      check("t2_lbu_val", last_data, 32'h0000_0080);
      op("t2_lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
      check("t2_lw_val", last_data, 32'h8022_3344);

      // Half store over zeroed memory
      op("t3_sh", 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_A5A5, 0);
      op("t3_lhs", 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 0);
      check("t3_lhs_val", last_data, 32'hFFFF_A5A5);
      op("t3_lw", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0);
      check("t3_lw_val", last_data, 32'hA5A5_0000);

      // Misaligned word load
      op("t4_sw", 1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFE_F00D, 0);
      op("t4_lw", 1'b0, 2'b10, 1'b0, 32'h31, 32'h0, 0);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      check("t4_trap_err", 32'(last_err), 32'd1);
      check("t4_trap_data", last_data, 32'h0);
      check("t4_trap_noen", 32'(last_en_seen), 32'd0);
`else
      check("t4_fix_val", last_data, 32'hCAFE_F00D);
      check("t4_fix_err", 32'(last_err), 32'd0);
      check("t4_fix_addr", 32'(last_en_addr), 32'hC);
`endif

      // Back-pressure on the response
      op("t5_lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5);

      // Reset during the write phase of a sub-word store
      op("t6_sw", 1'b1, 2'b10, 1'b0, 32'h40, 32'h1234_5678, 0);
      @(negedge Clock);
      ReqValid  = 1'b1;
      ReqWrite  = 1'b1;
      ReqSize   = 2'b00;
      ReqSigned = 1'b0;
      ReqAddr   = 18'h41;
      ReqWData  = 32'h0000_00AB;
      @(posedge Clock);
      #1 ReqValid = 1'b0;
      g = 0;
      do begin
         @(negedge Clock);
         g++;
      end while (!MemWriteEn && g < 10);
      check("t6_write_reached", 32'(MemWriteEn), 32'd1);
      #5 nReset = 1'b0;
      #1;
      check_reset_outputs("t6_rst");
      refb.delete();
      @(negedge Clock);
      nReset = 1'b1;
      op("t6_lw", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0);
      check("t6_lw_val", last_data, 32'h0);

      // Random traffic against the reference model
      for (int i = 0; i < 150; i++) begin
         bit          wr   = 1'($urandom_range(0, 1));
         logic [1:0]  sz   = 2'($urandom_range(0, 3));
         bit          sg   = 1'($urandom_range(0, 1));
         int unsigned a    = 32'h100 + $urandom_range(0, 63);
         logic [31:0] wd   = $urandom;
         int          hold = ($urandom_range(0, 7) == 0) ? 2 : 0;
         op("rnd", wr, sz, sg, a, wd, hold);
      end

      check("no_both_en", 32'(both_cnt), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
